mmio_disp_btn: RTL and testbench
================================

// Module: mmio_disp_btn
// PURPOSE
//   Memory-mapped I/O responder on the MIPS data-memory bus (we/addr/wd/rd); the core is the initiator.
//   - Output path: core writes a 16-bit value; the block shows it as 4 hex digits on a multiplexed 7-segment display.
//   - Input path: button switches (bsf, bs[3:0]) are synchronised, debounced and latched as press events the core can read.
//   - Sits beside datamem: the top decodes the I/O window and ORs rd.
// PARAMETERS
//   BASE_ADDR   32'h0000_FF00  byte address of register 0; window is BASE_ADDR..BASE_ADDR+0x1F
//   SCAN_DIV    50000          clk cycles each digit stays lit (>=2)
//   DEB_CYCLES  250000         cycles a synchronised input must be stable before it is accepted (>=1)
// PORTS
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   we       in   1   write strobe, sampled on posedge clk
//   addr     in   32  byte address; addr[1:0] ignored
//   wd       in   32  write data
//   rd       out  32  read data, combinational from addr; 0 outside window
//   bsf      in   1   button switch F (raw, asynchronous)
//   bs       in   4   button switches 3..0 (raw, asynchronous)
//   seg      out  8   segments {dp,g,f,e,d,c,b,a}, active-low
//   an       out  4   digit anodes, active-low, one-hot-low when enabled
//   irq      out  1   only with BTN_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
//   Register map (offset from BASE_ADDR):
//     0x00 DISP  R/W  [15:0] hex value; [19:16] dp per digit; upper bits read 0
//     0x04 BTN   RO   {27'b0, bsf_db, bs_db[3:0]} debounced levels
//     0x08 CTRL  R/W  [0] display enable; [1] blank leading zeros
//     0x0C EDGE  W1C  [4:0] sticky rising-edge flags of {bsf,bs}
//     0x10 MASK  R/W  [4:0] irq mask (present only with BTN_IRQ_EN, else reads 0)
//   Reset values (rst_n low, immediate):
//     - DISP=0, CTRL=0, EDGE=0, MASK=0
//     - debounced levels=0; sync flops=0; debounce and scan counters=0; digit index=0
//     - seg=8'hFF, an=4'hF, irq=0
//   Writes: DISP/CTRL/MASK update on the posedge with we=1 and matching addr; BTN writes ignored.
//   Out-of-window or unmapped offsets (0x14..0x1C): writes ignored, rd=0.
//   Input path, per bit independent:
//     - 2-flop synchroniser, then debounce counter.
//     - Counter clears whenever sync value == accepted level.
//     - Otherwise increments; at DEB_CYCLES-1 the accepted level flips and the counter clears.
//     - Latency raw->BTN = 2 + DEB_CYCLES cycles.
//   EDGE: bit sets on an accepted 0->1 transition.
//     - Cleared by writing 1 to that bit.
//     - Same-cycle set and W1C: set wins (flag stays 1).
//   Scan FSM: DIG0->DIG1->DIG2->DIG3->DIG0.
//     - Advances when the scan counter reaches SCAN_DIV-1; counter then wraps to 0.
//     - an[i]=0 only in state DIGi and only while CTRL[0]=1; CTRL[0]=0 -> an=4'hF, seg=8'hFF, scan keeps running.
//     - seg registered: hex decode of DISP nibble i, with dp from DISP[16+i].
//     - Display change takes effect on the next clock after the write.
//   Leading-zero blank (CTRL[1]): digit i blanked (seg=8'hFF, anode still cycles) if all nibbles >=i are 0 and i!=0.
//   Hex decode (active-low, a..g): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
//     - dp bit 7=0 when lit.
//   Reset asserted mid-scan or mid-debounce aborts immediately; no pending event survives.
// CONFIGURATION
//   BTN_IRQ_EN defined:
//     - MASK register and irq port exist.
//     - irq = |(EDGE & MASK), registered (1 cycle after the EDGE flag sets); drops the cycle after W1C clears it.
//   BTN_IRQ_EN undefined: no irq port, MASK offset reads 0 and ignores writes.
// TESTING (SCAN_DIV=4, DEB_CYCLES=3, BASE_ADDR=32'hFF00)
//   Reset: rst_n=0 mid-operation -> seg=8'hFF, an=4'hF, rd@FF00/FF04/FF08/FF0C=0 while low.
//   Display: write FF00=32'h1234, FF08=1 -> an steps E,D,B,7 every 4 clk; seg=99,B0,A4,F9 respectively.
//   Blanking: DISP=0x0005, CTRL=3 -> digits 1..3 seg=FF, digit0 seg=92; DISP=0 -> digit0 shows C0.
//   Debounce: bs[2] glitch of 2 cycles -> BTN stays 0.
//     - Held high -> FF04 reads 32'h4 exactly 5 cycles after the change; EDGE bit2=1.
//   W1C race: write FF0C=32'h4 in the same cycle bs[0] is accepted -> EDGE=32'h1 (bit0 kept, bit2 cleared).
//   IRQ (BTN_IRQ_EN): MASK=5'h10, press bsf -> irq=1 one cycle after EDGE[4]; write FF0C=0x10 -> irq=0 next cycle.
//     - Unmasked press -> irq stays 0.

Source files
------------

// File: rtl/mmio_disp_btn.sv
// mmio_disp_btn: MMIO responder that drives a multiplexed 4-digit 7-segment display and reports
// debounced button levels and press events. Define BTN_IRQ_EN to add the MASK register and irq.
module mmio_disp_btn #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        bsf,
    input  logic [3:0]  bs,
    output logic [7:0]  seg,
    output logic [3:0]  an
`ifdef BTN_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} dig_t;

    logic [31:0]   w_off;
    logic          w_hit;
    logic          w_wr;
    logic [2:0]    w_reg;
    logic          w_unused;
    logic [4:0]    w_w1c;
    logic [19:0]   r_disp;
    logic [1:0]    r_ctrl;
    logic [4:0]    r_edge;
    logic [4:0]    r_sync1;
    logic [4:0]    r_sync2;
    logic [4:0]    r_lvl;
    logic [DW-1:0] r_deb_cnt [5];
    logic [4:0]    w_flip;
    logic [4:0]    w_rise;
    logic [SW-1:0] r_scan_cnt;
    logic          w_scan_wrap;
    dig_t          r_dig;
    dig_t          w_dig_nxt;
    logic [3:0]    w_an;
    logic [1:0]    w_idx;
    logic [3:0]    w_nib;
    logic          w_dp;
    logic          w_blank;
    logic [7:0]    w_seg_nxt;
    logic [7:0]    r_seg;

    // Offset relative to the window base, so any BASE_ADDR works without alignment assumptions.
    assign w_off    = addr - BASE_ADDR;
    assign w_hit    = (w_off[31:5] == '0);
    assign w_reg    = w_off[4:2];
    assign w_wr     = we & w_hit;
    assign w_unused = ^{w_off[1:0], wd[31:20]};
    assign w_w1c    = (w_wr && (w_reg == 3'd3)) ? wd[4:0] : 5'd0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_ctrl <= '0;
            r_edge <= '0;
        end else begin
            if (w_wr && (w_reg == 3'd0)) r_disp <= wd[19:0];
            if (w_wr && (w_reg == 3'd2)) r_ctrl <= wd[1:0];
            // A new press outranks a simultaneous W1C of the same bit.
            r_edge <= (r_edge & ~w_w1c) | w_rise;
        end
    end

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < 5; i++)
            w_flip[i] = (r_sync2[i] != r_lvl[i]) && (r_deb_cnt[i] == DEB_LAST);
    end
    assign w_rise = w_flip & ~r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= {bsf, bs};
            r_sync2 <= r_sync1;
            r_lvl   <= r_lvl ^ w_flip;
            for (int i = 0; i < 5; i++) begin
                if ((r_sync2[i] == r_lvl[i]) || w_flip[i]) r_deb_cnt[i] <= '0;
                else r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
            end
        end
    end

    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dig <= DIG0;
        else r_dig <= w_dig_nxt;
    end

    always_comb begin
        w_dig_nxt = r_dig;
        w_an      = 4'hF;
        if (w_scan_wrap) begin
            case (r_dig)
                DIG0: w_dig_nxt = DIG1;
                DIG1: w_dig_nxt = DIG2;
                DIG2: w_dig_nxt = DIG3;
                default: w_dig_nxt = DIG0;
            endcase
        end
        if (r_ctrl[0]) begin
            case (r_dig)
                DIG0: w_an = 4'b1110;
                DIG1: w_an = 4'b1101;
                DIG2: w_an = 4'b1011;
                default: w_an = 4'b0111;
            endcase
        end
    end

    // Segments are decoded for the digit about to be selected so they stay aligned with an.
    always_comb begin
        w_idx = w_dig_nxt;
        w_nib = r_disp[{w_idx, 2'b00} +: 4];
        w_dp  = r_disp[5'd16 + {3'b000, w_idx}];
        case (w_idx)
            2'd1: w_blank = (r_disp[15:4] == '0);
            2'd2: w_blank = (r_disp[15:8] == '0);
            2'd3: w_blank = (r_disp[15:12] == '0);
            default: w_blank = 1'b0;
        endcase
        if (!r_ctrl[0] || (r_ctrl[1] && w_blank)) w_seg_nxt = 8'hFF;
        else w_seg_nxt = {~w_dp, hex7(w_nib)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_seg      <= 8'hFF;
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
            r_seg      <= w_seg_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = w_an;

`ifdef BTN_IRQ_EN
    logic [4:0] r_mask;
    logic       r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (w_reg == 3'd4)) r_mask <= wd[4:0];
            r_irq <= |(r_edge & r_mask);
        end
    end
    assign irq = r_irq;
`endif

    always_comb begin
        rd = '0;
        if (w_hit) begin
            case (w_reg)
                3'd0: rd = {12'd0, r_disp};
                3'd1: rd = {27'd0, r_lvl};
                3'd2: rd = {30'd0, r_ctrl};
                3'd3: rd = {27'd0, r_edge};
`ifdef BTN_IRQ_EN
                3'd4: rd = {27'd0, r_mask};
`endif
                default: rd = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_disp_btn.sv
// Bench for mmio_disp_btn: directed stimulus, a cycle-level behavioural model and literal spot checks.
module tb_mmio_disp_btn;
    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam int SD  = 4;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        bsf = 1'b0;
    logic [3:0]  bs = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
`ifdef BTN_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    mmio_disp_btn #(.BASE_ADDR(BASE), .SCAN_DIV(SD), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wd(wd), .rd(rd),
        .bsf(bsf), .bs(bs), .seg(seg), .an(an)
`ifdef BTN_IRQ_EN
        , .irq(irq)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Model state: register contents, accepted levels, edges since reset, raw sample history.
    logic [19:0] m_disp;
    logic [1:0]  m_ctrl;
    logic [4:0]  m_edge;
    logic [4:0]  m_lvl;
    logic [7:0]  m_seg;
    int          m_k;
    logic [4:0]  m_smp [$];
`ifdef BTN_IRQ_EN
    logic [4:0]  m_mask;
    logic        m_irq;
`endif

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_digit(input logic [19:0] d, input logic [1:0] c, input int i);
        logic [15:0] sh;
        logic [7:0]  r;
        if (!c[0]) return 8'hFF;
        sh = d[15:0] >> (4 * i);
        if (c[1] && (i != 0) && (sh == 16'd0)) return 8'hFF;
        r = hexseg(sh[3:0]);
        if (d[16 + i]) r[7] = 1'b0;
        return r;
    endfunction

    function automatic int reg_index(input logic [31:0] a);
        if (a < BASE || a >= BASE + 32'd32) return -1;
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        case (reg_index(a))
            0: return {12'd0, m_disp};
            1: return {27'd0, m_lvl};
            2: return {30'd0, m_ctrl};
            3: return {27'd0, m_edge};
`ifdef BTN_IRQ_EN
            4: return {27'd0, m_mask};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_disp = '0; m_ctrl = '0; m_edge = '0; m_lvl = '0;
        m_seg = 8'hFF; m_k = 0;
        m_smp.delete();
`ifdef BTN_IRQ_EN
        m_mask = '0; m_irq = 1'b0;
`endif
    endtask

    // A level is accepted once the synchronised input (raw delayed by two edges) has differed
    // from it on DEB consecutive edges.
    task automatic model_step();
        logic [4:0] flip, w1c;
        logic       s, all_diff;
        int         ri;
        flip = '0;
        for (int b = 0; b < 5; b++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                s = (m_smp.size() > 1 + j) ? m_smp[1 + j][b] : 1'b0;
                if (s == m_lvl[b]) all_diff = 1'b0;
            end
            flip[b] = all_diff;
        end
        ri  = we ? reg_index(addr) : -1;
        w1c = (ri == 3) ? wd[4:0] : 5'd0;
        m_seg = exp_digit(m_disp, m_ctrl, ((m_k + 1) / SD) % 4);
`ifdef BTN_IRQ_EN
        m_irq = |(m_edge & m_mask);
        if (ri == 4) m_mask = wd[4:0];
`endif
        m_edge = (m_edge & ~w1c) | (flip & ~m_lvl);
        m_lvl  = m_lvl ^ flip;
        if (ri == 0) m_disp = wd[19:0];
        if (ri == 2) m_ctrl = wd[1:0];
        m_k++;
        m_smp.push_front({bsf, bs});
        if (m_smp.size() > DEB + 2) void'(m_smp.pop_back());
    endtask

    task automatic check_outputs();
        logic [3:0] exp_an;
        exp_an = m_ctrl[0] ? ~(4'b0001 << ((m_k / SD) % 4)) : 4'hF;
        cmp("an", {28'd0, an}, {28'd0, exp_an});
        cmp("seg", {24'd0, seg}, {24'd0, m_seg});
        cmp("rd", rd, model_rd(addr));
`ifdef BTN_IRQ_EN
        cmp("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        cyc();
        we = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs();
        cmp("reset_seg", {24'd0, seg}, 32'h0000_00FF);
        cmp("reset_an", {28'd0, an}, 32'h0000_000F);
        rst_n = 1'b1;

        // Display scan of 0x1234
        wr(32'hFF00, 32'h0000_1234);
        wr(32'hFF08, 32'h1);
        addr = 32'hFF00;
        cyc();
        cmp("disp_an0", {28'd0, an}, 32'hE);   cmp("disp_seg0", {24'd0, seg}, 32'h99);
        cyc();
        cmp("disp_an1", {28'd0, an}, 32'hD);   cmp("disp_seg1", {24'd0, seg}, 32'hB0);
        repeat (4) cyc();
        cmp("disp_an2", {28'd0, an}, 32'hB);   cmp("disp_seg2", {24'd0, seg}, 32'hA4);
        repeat (4) cyc();
        cmp("disp_an3", {28'd0, an}, 32'h7);   cmp("disp_seg3", {24'd0, seg}, 32'hF9);
        repeat (4) cyc();
        cmp("disp_wrap", {24'd0, seg}, 32'h99);

        // Leading-zero blanking
        wr(32'hFF00, 32'h0000_0005);
        wr(32'hFF08, 32'h3);
        cyc();
        cmp("blank_d0", {24'd0, seg}, 32'h92);
        cyc();
        cmp("blank_d1_an", {28'd0, an}, 32'hD); cmp("blank_d1", {24'd0, seg}, 32'hFF);
        wr(32'hFF00, 32'h0);
        repeat (11) cyc();
        cmp("zero_an", {28'd0, an}, 32'hE);    cmp("zero_seg", {24'd0, seg}, 32'hC0);

        // Decimal point on digit 1, then out-of-window and unmapped writes
        wr(32'hFF00, 32'h0002_00A0);
        repeat (4) cyc();
        cmp("dp_an", {28'd0, an}, 32'hD);      cmp("dp_seg", {24'd0, seg}, 32'h08);
        wr(32'hFF20, 32'h0000_FFFF);
        wr(32'hFF14, 32'h1);
        addr = 32'hFF14;
        cyc();
        cmp("unmapped_rd", rd, 32'h0);
        addr = 32'hFF00;
        cyc();
        cmp("oow_ignored", rd, 32'h0002_00A0);
        wr(32'hFF08, 32'h0);
        cyc();
        cmp("off_an", {28'd0, an}, 32'hF);     cmp("off_seg", {24'd0, seg}, 32'hFF);

        // Debounce: short glitch rejected, held press accepted after 2+DEB cycles
        addr = 32'hFF04;
        bs = 4'b0100;
        repeat (2) cyc();
        bs = 4'b0000;
        repeat (8) cyc();
        cmp("glitch", rd, 32'h0);
        bs = 4'b0100;
        repeat (4) cyc();
        cmp("deb_early", rd, 32'h0);
        cyc();
        cmp("deb_accept", rd, 32'h4);
        addr = 32'hFF0C;
        cyc();
        cmp("edge_set", rd, 32'h4);

        // W1C of bit 2 in the same cycle bit 0 is accepted
        bs = 4'b0101;
        repeat (4) cyc();
        we = 1'b1; wd = 32'h4;
        cyc();
        we = 1'b0;
        cmp("w1c_race", rd, 32'h1);

`ifdef BTN_IRQ_EN
        wr(32'hFF10, 32'h10);
        addr = 32'hFF0C;
        bsf = 1'b1;
        repeat (5) cyc();
        cmp("irq_pre", {31'd0, irq}, 32'h0);   cmp("irq_edge", rd, 32'h11);
        cyc();
        cmp("irq_set", {31'd0, irq}, 32'h1);
        wr(32'hFF0C, 32'h10);
        cmp("irq_hold", {31'd0, irq}, 32'h1);
        cyc();
        cmp("irq_clr", {31'd0, irq}, 32'h0);
        bs = 4'b0111;
        repeat (8) cyc();
        cmp("irq_unmasked", {31'd0, irq}, 32'h0);
`else
        wr(32'hFF10, 32'h1F);
        addr = 32'hFF10;
        cyc();
        cmp("mask_absent", rd, 32'h0);
        bsf = 1'b1;
        bs = 4'b0111;
        repeat (8) cyc();
`endif

        // Asynchronous reset in the middle of scanning with buttons held
        wr(32'hFF00, 32'h0000_ABCD);
        wr(32'hFF08, 32'h1);
        repeat (3) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_seg", {24'd0, seg}, 32'hFF);
        cmp("rst_an", {28'd0, an}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            addr = BASE + 32'(4 * i);
            cyc();
            cmp($sformatf("rst_rd%0d", i), rd, 32'h0);
        end
        rst_n = 1'b1;
        addr = 32'hFF04;
        repeat (12) cyc();
        bsf = 1'b0;
        bs = 4'b0000;
        addr = 32'hFF0C;
        repeat (8) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
